// File: rtl/square_root_pkg.sv
// ---------------------------------------------------------------------------
// square_root_pkg : shared types and constants for the square-root unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package square_root_pkg;

  localparam int SQRT_WIDTH_DEF = 8;
  localparam int SQRT_CNT_W     = $clog2(SQRT_WIDTH_DEF);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } sqrt_state_e;

endpackage : square_root_pkg

`default_nettype wire

// File: rtl/sqrt_step.sv
// ---------------------------------------------------------------------------
// sqrt_step : one restoring digit-by-digit square-root iteration
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sqrt_step
  import square_root_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH_DEF
) (
  input  logic [WIDTH+1:0] rem_i,
  input  logic [WIDTH-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [WIDTH+1:0] rem_o,
  output logic             bit_o
);

  // Compared at full width so no remainder bits are silently dropped.
  logic [WIDTH+3:0] w_shifted;
  logic [WIDTH+3:0] w_trial;

  always_comb begin
    w_shifted = {rem_i, bits_i};
    w_trial   = {2'b00, root_i, 2'b01};
    if (w_shifted >= w_trial) begin
      bit_o = 1'b1;
      rem_o = (WIDTH+2)'(w_shifted - w_trial);
    end else begin
      bit_o = 1'b0;
      rem_o = (WIDTH+2)'(w_shifted);
    end
  end

endmodule : sqrt_step

`default_nettype wire

// File: rtl/square_root.sv
// ---------------------------------------------------------------------------
// square_root : sequential Q(W/2).(W/2) square root, Q = floor(sqrt(A<<W))
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module square_root
  import square_root_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  sqrt_state_e          state_q,   state_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [2*WIDTH-1:0]   rad_q,     rad_d;
  logic [WIDTH+1:0]     rem_q,     rem_d;
  logic [WIDTH-1:0]     root_q,    root_d;
  logic [WIDTH-1:0]     q_q,       q_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;

  logic [WIDTH+1:0]     step_rem;
  logic                 step_bit;

  sqrt_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[2*WIDTH-1 -: 2]),
    .rem_o  (step_rem),
    .bit_o  (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    q_d       = q_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          rad_d     = {A, {WIDTH{1'b0}}};
          rem_d     = '0;
          root_d    = '0;
          counter_d = CNT_W'(WIDTH - 1);
          busy_d    = 1'b1;
        end
      end
      CALC: begin
        rad_d     = {rad_q[2*WIDTH-3:0], 2'b00};
        rem_d     = step_rem;
        root_d    = {root_q[WIDTH-2:0], step_bit};
        counter_d = counter_q - 1'b1;
        // Last step: publish the root directly from the step output.
        if (counter_q == '0) begin
          q_d     = {root_q[WIDTH-2:0], step_bit};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q   <= IDLE;
      counter_q <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      q_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      q_q       <= q_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Q    = q_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : square_root

`default_nettype wire

// File: tb/tb_square_root.sv
// ---------------------------------------------------------------------------
// tb_square_root : scoreboard bench for square_root (WIDTH = 8)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_square_root;

  logic       clk;
  logic       rst_;
  logic       start;
  logic [7:0] A;
  logic [7:0] Q;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  square_root #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_  (rst_),
    .start (start),
    .A     (A),
    .Q     (Q),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: largest r with r*r <= v.
  function automatic logic [7:0] ref_sqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return 8'(r);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_ && done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got done=1 Q=%0d, required no done", Q);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (Q !== e) begin
          n_err++;
          $display("FAIL result: got Q=%0d, required %0d", Q, e);
        end
      end
    end
  end

  // Called at a negedge: wait for done, returning negedges elapsed (bounded).
  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clk);
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] e);
    int lat;
    start = 1'b1;
    A     = a;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A     = ~a;
    lat   = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 9);
    @(negedge clk);
    check("done_width", int'(done), 0);
  endtask

  initial begin
    rst_  = 1'b0;
    start = 1'b1;
    A     = 8'd128;

    // Reset with start asserted: outputs stay cleared.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_Q", int'(Q), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
    end
    rst_ = 1'b1;
    run_one(8'd128, 8'd181);

    // Directed vectors.
    run_one(8'd0,   8'd0);
    run_one(8'd1,   8'd16);
    run_one(8'd4,   8'd32);
    run_one(8'd100, 8'd160);
    run_one(8'd255, 8'd255);

    // start held high, A toggled after each done: 64, 22, 64, 22.
    begin
      int lat;
      start = 1'b1;
      A     = 8'd16;
      exp_q.push_back(8'd64);
      for (int i = 0; i < 4; i++) begin
        wait_done(lat);
        check("b2b_period", lat, 9);
        if (i < 3) begin
          A = (i % 2 == 0) ? 8'd2 : 8'd16;
          exp_q.push_back((i % 2 == 0) ? 8'd22 : 8'd64);
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
    end

    // Mid-computation start/A change is ignored and not queued.
    begin
      int lat;
      int extra;
      start = 1'b1;
      A     = 8'd128;
      exp_q.push_back(8'd181);
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 30) begin
        if (lat == 4) begin
          A     = 8'd9;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
      start = 1'b0;
      check("midstart_latency", lat, 9);
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("midstart_not_queued", extra, 0);
    end

    // Reset during a computation after a previous result of 64.
    run_one(8'd16, 8'd64);
    begin
      int extra;
      start = 1'b1;
      A     = 8'd128;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i < 5; i++) @(negedge clk);
      rst_ = 1'b0;
      @(negedge clk);
      rst_ = 1'b1;
      check("abort_Q", int'(Q), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("abort_no_done", extra, 0);
    end
    run_one(8'd49, 8'd112);

    // Full operand sweep against the reference model.
    for (int a = 0; a < 256; a++) begin
      run_one(8'(a), ref_sqrt(a * 256));
    end

    repeat (3) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by t=%0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_square_root

`default_nettype wire
